inc_share_ctrl: RTL and testbench

- Round-robin controller that shares one WIDTH-bit increment unit (Y = A + 1, with carry-out) among NREQ requesters.
- Each requester presents an operand with a valid/ready handshake. The controller grants one requester, sequences the operand through the incrementer and returns the result, carry-out and requester ID on a single response channel with valid/ready back-pressure.
- Sits between the ALU operand sources and the shared increment datapath.

---
 rtl/inc_share_pkg.sv | 34 +++
 rtl/inc_unit.sv | 12 +
 rtl/inc_share_ctrl.sv | 109 ++++++++++
 tb/tb_inc_share_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/inc_share_pkg.sv
// rtl/inc_share_pkg.sv - shared types and round-robin grant helper for inc_share_ctrl
package inc_share_pkg;

  localparam int MAX_NREQ = 8;
  localparam int PTR_W    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Vectors are sized for the largest supported NREQ; bits at or above nreq stay zero.
  function automatic logic [MAX_NREQ-1:0] rr_next(
    input logic [MAX_NREQ-1:0] valid,
    input logic [PTR_W-1:0]    ptr,
    input int                  nreq
  );
    logic [MAX_NREQ-1:0] g;
    logic                found;
    int                  idx;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      idx = (int'(ptr) + i) % nreq;
      if (i < nreq && !found && valid[idx[PTR_W-1:0]]) begin
        g[idx[PTR_W-1:0]] = 1'b1;
        found             = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/inc_unit.sv
// rtl/inc_unit.sv - shared combinational incrementer, y = a + 1 with carry-out
module inc_unit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y,
  output logic             cout
);

  assign {cout, y} = {1'b0, a} + (WIDTH+1)'(1);

endmodule

// File: rtl/inc_share_ctrl.sv
// rtl/inc_share_ctrl.sv - round-robin sharing of one incrementer among NREQ requesters
module inc_share_ctrl
  import inc_share_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_cout,
  input  logic                  rsp_ready,
  output logic                  busy
);

  state_t               state, state_nxt;
  logic [IDW-1:0]       rr_ptr;
  logic [IDW-1:0]       id_q;
  logic [WIDTH-1:0]     op_q;
  logic [MAX_NREQ-1:0]  grant_full;
  logic [IDW-1:0]       grant_idx;
  logic [WIDTH-1:0]     op_sel;
  logic [WIDTH-1:0]     sum;
  logic                 cout;

  assign grant_full = rr_next(MAX_NREQ'(req_valid), PTR_W'(rr_ptr), NREQ);

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      if (grant_full[i]) grant_idx = IDW'(i);
    end
  end

  always_comb begin
    op_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) op_sel = req_data[i*WIDTH +: WIDTH];
    end
  end

  inc_unit #(.WIDTH(WIDTH)) u_inc (
    .a    (op_q),
    .y    (sum),
    .cout (cout)
  );

  // Grant is combinational in IDLE, so it must be masked while reset is asserted.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (!reset && |req_valid) begin
          req_ready = grant_full[NREQ-1:0];
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id_q      <= '0;
      op_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            op_q <= op_sel;
            id_q <= grant_idx;
          end
        end
        EXEC: begin
          rsp_data  <= sum;
          rsp_cout  <= cout;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= (int'(id_q) == NREQ-1) ? '0 : id_q + IDW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inc_share_ctrl.sv
// tb/tb_inc_share_ctrl.sv - directed self-checking bench for inc_share_ctrl
module tb_inc_share_ctrl;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_cout;
  logic                  rsp_ready;
  logic                  busy;

  int checks = 0;
  int errors = 0;

  inc_share_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_cout  (rsp_cout),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive in IDLE, check grant, then walk EXEC -> RESP -> accept.
  task automatic serve(input string tag, input logic [NREQ-1:0] exp_grant,
                       input logic [31:0] exp_id, input logic [31:0] exp_data,
                       input logic [31:0] exp_cout);
    #1;
    chk({tag, "_grant"}, 32'(req_ready), 32'(exp_grant));
    tick();
    chk({tag, "_exec_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_id"}, 32'(rsp_id), exp_id);
    chk({tag, "_data"}, 32'(rsp_data), exp_data);
    chk({tag, "_cout"}, 32'(rsp_cout), exp_cout);
    tick();
    chk({tag, "_done"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 4'b1111;
    req_data  = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_cout", 32'(rsp_cout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    req_valid = 4'b0000;
    reset     = 1'b0;
    rsp_ready = 1'b1;
    tick();
    chk("idle_no_grant", 32'(req_ready), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Single requester
    req_valid = 4'b0001;
    req_data  = 32'h0000_003C;
    serve("single", 4'b0001, 0, 32'h3D, 0);
    req_valid = 4'b0000;

    // Wrap-around on requester 2
    req_valid = 4'b0100;
    req_data  = 32'h00FF_0000;
    serve("wrap_ff", 4'b0100, 2, 32'h00, 1);
    req_data  = 32'h00FE_0000;
    serve("wrap_fe", 4'b0100, 2, 32'hFF, 0);
    req_valid = 4'b0000;

    // Round-robin from pointer 0
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    req_valid = 4'b1111;
    req_data  = 32'h4030_2010;
    serve("rr0", 4'b0001, 0, 32'h11, 0);
    serve("rr1", 4'b0010, 1, 32'h21, 0);
    serve("rr2", 4'b0100, 2, 32'h31, 0);
    serve("rr3", 4'b1000, 3, 32'h41, 0);
    serve("rr4", 4'b0001, 0, 32'h11, 0);

    // Back-pressure: pointer is now 1
    rsp_ready = 1'b0;
    #1;
    chk("bp_grant", 32'(req_ready), 32'b0010);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_id", 32'(rsp_id), 32'd1);
      chk("bp_data", 32'(rsp_data), 32'h21);
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
    tick();
    chk("bp_released", 32'(rsp_valid), 32'd0);
    chk("bp_next_grant", 32'(req_ready), 32'b0100);

    // Reset mid-operation: pointer 2, only requester 1 asks
    req_valid = 4'b0010;
    #1;
    chk("rmo_grant", 32'(req_ready), 32'b0010);
    tick();
    chk("rmo_exec_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    chk("rmo_ready", 32'(req_ready), 32'd0);
    chk("rmo_valid", 32'(rsp_valid), 32'd0);
    chk("rmo_id", 32'(rsp_id), 32'd0);
    chk("rmo_data", 32'(rsp_data), 32'd0);
    chk("rmo_cout", 32'(rsp_cout), 32'd0);
    chk("rmo_busy", 32'(busy), 32'd0);
    reset     = 1'b0;
    req_valid = 4'b0110;
    serve("rmo_after", 4'b0010, 1, 32'h21, 0);

    // Skip idle requesters: serve 0 to reach pointer 1, then 3 and 0 request
    req_valid = 4'b0001;
    serve("skip_setup", 4'b0001, 0, 32'h11, 0);
    req_valid = 4'b1001;
    serve("skip3", 4'b1000, 3, 32'h41, 0);
    serve("skip0", 4'b0001, 0, 32'h11, 0);
    req_valid = 4'b0000;
    #1;
    chk("end_idle", 32'(req_ready), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
